// File: rtl/tapped_fifo_valid_pkg.sv
// Shared helpers for the flow-controlled tapped FIFO: constant log2 for
// sizing the fill counter and the legal depth floor.
package tapped_fifo_valid_pkg;

    localparam int MIN_DEPTH = 2;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tapped_fifo_valid_stage.sv
// One WIDTH-bit delay stage of the tapped FIFO: async active-low reset,
// synchronous clear taking priority over the shift enable.
module tapped_fifo_valid_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Stage register: clear beats enable, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= '0;
        end else if (clear) begin
            q_r <= '0;
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/tapped_fifo_valid.sv
// Flow-controlled tapped shift register with fill tracking and a registered
// eviction port. Optional fill_count port enabled by TAPPED_FIFO_COUNT_EN.
module tapped_fifo_valid
    import tapped_fifo_valid_pkg::*;
#(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 10,
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic [WIDTH*DEPTH-1:0] taps,
    output logic                   taps_valid,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data
`ifdef TAPPED_FIFO_COUNT_EN
    ,
    output logic [CW-1:0]          fill_count
`endif
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    if (DEPTH < MIN_DEPTH) begin : g_depth_check
        $error("tapped_fifo_valid: DEPTH must be at least 2");
    end

    logic [WIDTH-1:0] stage_q_s [DEPTH];
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;
    logic             shift_s;
    logic             full_s;

    assign shift_s = in_valid & ~clear;
    assign full_s  = (count_r == FULL_COUNT);

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] d_s;
        if (i == 0) begin : g_head
            assign d_s = in_data;
        end else begin : g_body
            assign d_s = stage_q_s[i-1];
        end

        tapped_fifo_valid_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .clear (clear),
            .en    (shift_s),
            .d     (d_s),
            .q     (stage_q_s[i])
        );

        assign taps[i*WIDTH +: WIDTH] = stage_q_s[i];
    end

    // Fill level and eviction port; a shift while full pushes out the oldest word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r     <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (clear) begin
            count_r     <= '0;
            out_data_r  <= out_data_r;
            out_valid_r <= 1'b0;
        end else if (in_valid) begin
            if (full_s) begin
                count_r     <= count_r;
                out_data_r  <= stage_q_s[DEPTH-1];
                out_valid_r <= 1'b1;
            end else begin
                count_r     <= count_r + CW'(1);
                out_data_r  <= out_data_r;
                out_valid_r <= 1'b0;
            end
        end else begin
            count_r     <= count_r;
            out_data_r  <= out_data_r;
            out_valid_r <= 1'b0;
        end
    end

    assign taps_valid = full_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
`ifdef TAPPED_FIFO_COUNT_EN
    assign fill_count = count_r;
`endif

endmodule
